// File: rtl/ddp_arith_pkg.sv
// Shared constants, FSM encoding and limb helpers for the Montgomery datapath
// modular subtractor.
package ddp_arith_pkg;

   localparam int WIDTH     = 514;
   localparam int LIMB_W    = 180;
   localparam int NUM_LIMBS = (WIDTH + LIMB_W - 1) / LIMB_W;
   localparam int TOP_W     = WIDTH - (NUM_LIMBS - 1) * LIMB_W;

   localparam logic [1:0] LAST_LIMB = 2'(NUM_LIMBS - 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SUB     = 2'd1;
   localparam logic [1:0] ST_CORRECT = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   // The top limb is zero-extended to LIMB_W so one adder width serves every limb.
   function automatic logic [LIMB_W-1:0] get_limb(input logic [WIDTH-1:0] v,
                                                  input logic [1:0]       k);
      logic [LIMB_W-1:0] l;
      case (k)
         2'd0:    l = v[0 +: LIMB_W];
         2'd1:    l = v[LIMB_W +: LIMB_W];
         2'd2:    l = {{(LIMB_W - TOP_W){1'b0}}, v[2*LIMB_W +: TOP_W]};
         default: l = {LIMB_W{1'b0}};
      endcase
      return l;
   endfunction

   // Bits of the top-limb sum above WIDTH are dropped here.
   function automatic logic [WIDTH-1:0] put_limb(input logic [WIDTH-1:0]  r,
                                                 input logic [1:0]        k,
                                                 input logic [LIMB_W-1:0] s);
      logic [WIDTH-1:0] o;
      o = r;
      case (k)
         2'd0:    o[0 +: LIMB_W]      = s;
         2'd1:    o[LIMB_W +: LIMB_W] = s;
         2'd2:    o[2*LIMB_W +: TOP_W] = s[TOP_W-1:0];
         default: o = r;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/mod_sub_limb.sv
// One LIMB_W-bit ripple adder slice shared by the subtract and add-back passes.
module mod_sub_limb
   import ddp_arith_pkg::*;
(
   input  logic [LIMB_W-1:0] a,
   input  logic [LIMB_W-1:0] b,
   input  logic              cin,
   output logic [LIMB_W-1:0] s,
   output logic              cout
);

   logic [LIMB_W:0] sum_s;

   // Full-width sum including the carry out.
   always_comb begin
      sum_s = {1'b0, a} + {1'b0, b} + {{LIMB_W{1'b0}}, cin};
   end

   assign s    = sum_s[LIMB_W-1:0];
   assign cout = sum_s[LIMB_W];

endmodule

// File: rtl/mod_sub_514.sv
// Limb-serial modular subtractor: (in_a - in_b) mod in_m with a start/done handshake.
// Define MOD_SUB_CONST_TIME_EN to always run the add-back pass (fixed latency).
module mod_sub_514
   import ddp_arith_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_m,
   output logic [WIDTH-1:0] result,
   output logic             borrow,
   output logic             busy,
   output logic             done
);

   logic [1:0]        state_r;
   logic [1:0]        state_next_s;
   logic [1:0]        limb_r;
   logic              carry_r;
   logic [WIDTH-1:0]  a_r;
   logic [WIDTH-1:0]  b_r;
   logic [WIDTH-1:0]  m_r;
   logic [WIDTH-1:0]  result_r;
   logic              borrow_r;
   logic              busy_r;
   logic              done_r;
   logic              last_s;
   logic [LIMB_W-1:0] op_a_s;
   logic [LIMB_W-1:0] op_b_s;
   logic [LIMB_W-1:0] sum_s;
   logic              cout_s;

   mod_sub_limb u_limb (
      .a    (op_a_s),
      .b    (op_b_s),
      .cin  (carry_r),
      .s    (sum_s),
      .cout (cout_s)
   );

   assign last_s = (limb_r == LAST_LIMB);

   // Operand mux: a + ~b while subtracting, r + m (or r + 0) while correcting.
   always_comb begin
      op_a_s = {LIMB_W{1'b0}};
      op_b_s = {LIMB_W{1'b0}};
      case (state_r)
         ST_SUB: begin
            op_a_s = get_limb(a_r, limb_r);
            op_b_s = ~get_limb(b_r, limb_r);
         end
         ST_CORRECT: begin
            op_a_s = get_limb(result_r, limb_r);
`ifdef MOD_SUB_CONST_TIME_EN
            if (borrow_r) begin
               op_b_s = get_limb(m_r, limb_r);
            end else begin
               op_b_s = {LIMB_W{1'b0}};
            end
`else
            op_b_s = get_limb(m_r, limb_r);
`endif
         end
         default: begin
            op_a_s = {LIMB_W{1'b0}};
            op_b_s = {LIMB_W{1'b0}};
         end
      endcase
   end

   // Next-state logic; start is only honoured in IDLE and DONE.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_next_s = ST_SUB;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_SUB: begin
            if (last_s) begin
`ifdef MOD_SUB_CONST_TIME_EN
               state_next_s = ST_CORRECT;
`else
               if (!cout_s) begin
                  state_next_s = ST_CORRECT;
               end else begin
                  state_next_s = ST_DONE;
               end
`endif
            end else begin
               state_next_s = ST_SUB;
            end
         end
         ST_CORRECT: begin
            if (last_s) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_CORRECT;
            end
         end
         ST_DONE: begin
            if (start) begin
               state_next_s = ST_SUB;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // State, datapath registers and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         limb_r   <= 2'd0;
         carry_r  <= 1'b0;
         a_r      <= {WIDTH{1'b0}};
         b_r      <= {WIDTH{1'b0}};
         m_r      <= {WIDTH{1'b0}};
         result_r <= {WIDTH{1'b0}};
         borrow_r <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r <= state_next_s;
         busy_r  <= (state_next_s == ST_SUB) || (state_next_s == ST_CORRECT);
         done_r  <= (state_r == ST_DONE);
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  a_r     <= in_a;
                  b_r     <= in_b;
                  m_r     <= in_m;
                  limb_r  <= 2'd0;
                  carry_r <= 1'b1;
               end
            end
            ST_SUB: begin
               result_r <= put_limb(result_r, limb_r, sum_s);
               if (last_s) begin
                  borrow_r <= ~cout_s;
                  carry_r  <= 1'b0;
                  limb_r   <= 2'd0;
               end else begin
                  carry_r  <= cout_s;
                  limb_r   <= limb_r + 2'd1;
               end
            end
            ST_CORRECT: begin
               result_r <= put_limb(result_r, limb_r, sum_s);
               if (last_s) begin
                  carry_r <= 1'b0;
                  limb_r  <= 2'd0;
               end else begin
                  carry_r <= cout_s;
                  limb_r  <= limb_r + 2'd1;
               end
            end
            default: begin
               limb_r <= 2'd0;
            end
         endcase
      end
   end

   assign result = result_r;
   assign borrow = borrow_r;
   assign busy   = busy_r;
   assign done   = done_r;

endmodule

// File: tb/tb_mod_sub_514.sv
// Directed and random checks of mod_sub_514 against hand-computed values and a
// plain modular-arithmetic reference.
module tb_mod_sub_514;

   localparam int W = 514;
`ifdef MOD_SUB_CONST_TIME_EN
   localparam int LAT_NB = 7;
`else
   localparam int LAT_NB = 4;
`endif
   localparam int LAT_B = 7;

   logic         clk;
   logic         reset;
   logic         start;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic [W-1:0] in_m;
   logic [W-1:0] result;
   logic         borrow;
   logic         busy;
   logic         done;

   int checks;
   int passed;

   mod_sub_514 dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .in_a   (in_a),
      .in_b   (in_b),
      .in_m   (in_m),
      .result (result),
      .borrow (borrow),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [W-1:0] rand_w();
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < 17; i++) v = (v << 32) | W'($urandom);
      return v;
   endfunction

   // Start one operation, scramble inputs after acceptance, wait for done.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m,
                         input logic [W-1:0] exp_r, input logic exp_bw, input int exp_lat,
                         input string tag);
      int n;
      @(negedge clk);
      in_a = a; in_b = b; in_m = m; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      in_a = ~a; in_b = ~b; in_m = ~m;
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_done"}, W'(done), W'(1));
      chk({tag, "_lat"}, W'(n), W'(exp_lat));
      chk({tag, "_result"}, result, exp_r);
      chk({tag, "_borrow"}, W'(borrow), W'(exp_bw));
      @(posedge clk); #1;
   endtask

   initial begin
      logic [W-1:0] a, b, m, e, all1, one;
      int n, dc;
      logic [W-1:0] rr;
      checks = 0; passed = 0;
      one = W'(1);
      all1 = ~(W'(0));
      reset = 1'b1; start = 1'b0; in_a = '0; in_b = '0; in_m = '0;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_result", result, W'(0));
      chk("rst_borrow", W'(borrow), W'(0));
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_done", W'(done), W'(0));
      @(negedge clk); reset = 1'b0;

      run_op(W'(10), W'(3), W'(13), W'(7), 1'b0, LAT_NB, "t1");
      run_op(W'(3), W'(10), W'(13), W'(6), 1'b1, LAT_B, "t2");
      run_op(all1 - one, all1 - one, all1, W'(0), 1'b0, LAT_NB, "t3");
      run_op(one << 180, one, one << 513, (one << 180) - one, 1'b0, LAT_NB, "t4");

      // Start pulses in SUB and in CORRECT must be ignored.
      @(negedge clk);
      in_a = W'(3); in_b = W'(10); in_m = W'(13); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dc = 0; rr = '0;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin dc++; rr = result; end
         start = (c == 1 || c == 4) ? 1'b1 : 1'b0;
         in_a = (c == 1 || c == 4) ? W'(12) : W'(3);
      end
      start = 1'b0;
      chk("t5_done_count", W'(dc), W'(1));
      chk("t5_result", rr, W'(6));
      chk("t5_idle_busy", W'(busy), W'(0));

      // Reset in the middle of SUB.
      @(negedge clk);
      in_a = W'(10); in_b = W'(3); in_m = W'(13); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("t5_rst_result", result, W'(0));
      chk("t5_rst_borrow", W'(borrow), W'(0));
      chk("t5_rst_busy", W'(busy), W'(0));
      chk("t5_rst_done", W'(done), W'(0));
      reset = 1'b0;
      dc = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (done === 1'b1) dc++;
      end
      chk("t5_no_done_after_rst", W'(dc), W'(0));
      run_op(W'(3), W'(10), W'(13), W'(6), 1'b1, LAT_B, "t5_post");

      // Back-to-back: start held high through DONE.
      @(negedge clk);
      in_a = W'(10); in_b = W'(3); in_m = W'(13); start = 1'b1;
      @(posedge clk); #1;
      in_a = W'(3); in_b = W'(10); in_m = W'(13);
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      chk("t6_op1_lat", W'(n), W'(LAT_NB));
      chk("t6_op1_result", result, W'(7));
      chk("t6_no_idle_busy", W'(busy), W'(1));
      n = 0;
      @(posedge clk); #1;
      n++;
      while (done !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("t6_op2_lat", W'(n), W'(LAT_B));
      chk("t6_op2_result", result, W'(6));
      chk("t6_op2_borrow", W'(borrow), W'(1));
      @(posedge clk); #1;

      // Random vectors against a plain modular reference.
      for (int i = 0; i < 20; i++) begin
         m = rand_w();
         if (i % 4 == 0) m = m >> $urandom_range(500, 1);
         if (m == '0) m = one;
         a = rand_w() % m;
         b = rand_w() % m;
         e = (a >= b) ? (a - b) : (a - b + m);
         run_op(a, b, m, e, (a < b) ? 1'b1 : 1'b0, (a < b) ? LAT_B : LAT_NB, "rnd");
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
